// File: rtl/lfsr_checker_if.sv
// Sample/result bundle between an LFSR stream source and lfsr_checker.
// Wrap outputs exist only when LFSR_CHECKER_WRAP_EN is defined.
interface lfsr_checker_if #(
  parameter int CNT_W = 8
);
  logic             ena;
  logic [3:0]       din;
  logic             clr;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] err_count;
`ifdef LFSR_CHECKER_WRAP_EN
  logic             wrap;
  logic [CNT_W-1:0] wrap_count;
`endif

  modport master (
    output ena, din, clr,
    input  locked, err, err_count
`ifdef LFSR_CHECKER_WRAP_EN
    , input wrap, wrap_count
`endif
  );

  modport slave (
    input  ena, din, clr,
    output locked, err, err_count
`ifdef LFSR_CHECKER_WRAP_EN
    , output wrap, wrap_count
`endif
  );
endinterface

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the x^4+x^3+1 LFSR stream; registered outputs, one-cycle latency.
// No backpressure: samples are taken whenever ena is high. Optional wrap marker: LFSR_CHECKER_WRAP_EN.
module lfsr_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int LOSE_COUNT = 3,
  parameter int CNT_W      = 8
) (
  input logic          clk,
  input logic          rst,
  lfsr_checker_if.slave bus
);
  typedef enum logic [1:0] {HUNT = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [3:0]       LOCK_N  = 4'(LOCK_COUNT);
  localparam logic [3:0]       LOSE_N  = 4'(LOSE_COUNT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [3:0]       exp_q, exp_d;
  logic [3:0]       match_q, match_d;
  logic [3:0]       miss_q, miss_d;
  logic             locked_q;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef LFSR_CHECKER_WRAP_EN
  logic             wrap_q, wrap_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
`endif

  function automatic logic [3:0] nxt(input logic [3:0] x);
    return {x[2:0], x[2] ^ x[3]};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_ONE;
  endfunction

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    match_d = match_q;
    miss_d  = miss_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
`ifdef LFSR_CHECKER_WRAP_EN
    wrap_d  = 1'b0;
    wcnt_d  = wcnt_q;
`endif
    // Clear first so a same-cycle event counts from zero.
    if (bus.clr) begin
      cnt_d = '0;
`ifdef LFSR_CHECKER_WRAP_EN
      wcnt_d = '0;
`endif
    end
    if (bus.ena) begin
      case (state_q)
        HUNT: begin
          if (bus.din != 4'd0) begin
            exp_d   = nxt(bus.din);
            match_d = 4'd0;
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          if (bus.din == 4'd0) begin
            state_d = HUNT;
          end else if (bus.din == exp_q) begin
            exp_d   = nxt(exp_q);
            match_d = match_q + 4'd1;
            if (match_q + 4'd1 == LOCK_N) begin
              state_d = LOCKED;
              miss_d  = 4'd0;
            end
          end else begin
            exp_d   = nxt(bus.din);
            match_d = 4'd0;
          end
        end
        LOCKED: begin
          // Free-running prediction: din never reseeds once locked.
          exp_d = nxt(exp_q);
          if (bus.din == exp_q) begin
            miss_d = 4'd0;
`ifdef LFSR_CHECKER_WRAP_EN
            if (bus.din == 4'd1) begin
              wrap_d = 1'b1;
              wcnt_d = sat_inc(wcnt_d);
            end
`endif
          end else begin
            err_d  = 1'b1;
            cnt_d  = sat_inc(cnt_d);
            miss_d = miss_q + 4'd1;
            if (miss_q + 4'd1 == LOSE_N) begin
              state_d = HUNT;
              miss_d  = 4'd0;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= HUNT;
      exp_q    <= 4'd0;
      match_q  <= 4'd0;
      miss_q   <= 4'd0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
`ifdef LFSR_CHECKER_WRAP_EN
      wrap_q   <= 1'b0;
      wcnt_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      locked_q <= (state_d == LOCKED);
      err_q    <= err_d;
      cnt_q    <= cnt_d;
`ifdef LFSR_CHECKER_WRAP_EN
      wrap_q   <= wrap_d;
      wcnt_q   <= wcnt_d;
`endif
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err       = err_q;
  assign bus.err_count = cnt_q;
`ifdef LFSR_CHECKER_WRAP_EN
  assign bus.wrap       = wrap_q;
  assign bus.wrap_count = wcnt_q;
`endif
endmodule
